// File: rtl/pb_timer_sched.sv
// Four virtual 16-bit timer channels sharing one decrementer, scanned one channel
// per clock on each prescaler tick; Picoblaze port_id/strobe register interface.
module pb_timer_sched #(
   parameter logic [7:0] BASE_ADDRESS = 8'h00,
   parameter int         NUM_CH       = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] port_id,
   input  logic [7:0] data_in,
   output logic [7:0] data_out,
   input  logic       read_strobe,
   input  logic       write_strobe,
   output logic       interrupt
);

   typedef enum logic {S_IDLE, S_SCAN} state_t;

   state_t                   r_state;
   logic [1:0]               r_ch;
   logic                     r_gen;
   logic                     r_ovr;
   logic                     r_tick_q;
   logic [7:0]               r_prescale;
   logic [7:0]               r_pcnt;
   logic [NUM_CH-1:0]        r_ch_en;
   logic [NUM_CH-1:0]        r_oneshot;
   logic [NUM_CH-1:0]        r_pending;
   logic [NUM_CH-1:0]        r_mask;
   logic [NUM_CH-1:0][15:0]  r_period;
   logic [NUM_CH-1:0][15:0]  r_count;

   logic                     w_sel;
   logic                     w_wr;
   logic                     w_rd;
   logic [3:0]               w_off;
   logic [1:0]               w_idx;
   logic                     w_ps_wr;
   logic                     w_tick;
   logic                     w_visit;
   logic [15:0]              w_cur;
   logic [15:0]              w_dec;
   logic                     w_expire;
   logic [NUM_CH-1:0]        w_set;
   logic [NUM_CH-1:0]        w_w1c;
   logic [7:0]               w_rdata;

   assign w_sel    = (port_id[7:4] == BASE_ADDRESS[7:4]);
   assign w_off    = port_id[3:0];
   assign w_idx    = w_off[2:1];
   assign w_wr     = write_strobe & w_sel;
   assign w_rd     = read_strobe & w_sel;
   assign w_ps_wr  = w_wr && (w_off == 4'h1);
   assign w_tick   = r_gen && (r_pcnt == r_prescale) && !w_ps_wr;

   // One shared decrementer, steered by the channel under visit
   assign w_visit  = (r_state == S_SCAN);
   assign w_cur    = r_count[r_ch];
   assign w_dec    = w_cur - 16'd1;
   assign w_expire = w_visit && r_ch_en[r_ch] && (w_cur == 16'd0);
   assign w_set    = w_expire ? (NUM_CH'(1) << r_ch) : '0;
   assign w_w1c    = (w_wr && (w_off == 4'h4)) ? data_in[NUM_CH-1:0] : '0;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         r_pcnt <= 8'h00;
      else if (!r_gen || w_ps_wr || w_tick)
         r_pcnt <= 8'h00;
      else
         r_pcnt <= r_pcnt + 8'd1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state    <= S_IDLE;
         r_ch       <= 2'd0;
         r_gen      <= 1'b0;
         r_ovr      <= 1'b0;
         r_tick_q   <= 1'b0;
         r_prescale <= 8'h00;
         r_ch_en    <= '0;
         r_oneshot  <= '0;
         r_pending  <= '0;
         r_mask     <= '0;
         r_period   <= '0;
         r_count    <= '0;
      end else begin
         if (w_rd && (w_off == 4'h0))
            r_ovr <= 1'b0;

         case (r_state)
            S_IDLE: begin
               if (r_tick_q || w_tick) begin
                  r_state  <= S_SCAN;
                  r_ch     <= 2'd0;
                  // a fresh tick landing as the stored one is consumed stays queued
                  r_tick_q <= r_tick_q & w_tick;
               end
            end
            S_SCAN: begin
               r_ch <= r_ch + 2'd1;
               if (r_ch == 2'd3)
                  r_state <= S_IDLE;
               if (w_tick) begin
                  if (r_tick_q)
                     r_ovr <= 1'b1;
                  else
                     r_tick_q <= 1'b1;
               end
            end
            default: r_state <= S_IDLE;
         endcase

         if (!r_gen)
            r_tick_q <= 1'b0;

         if (w_visit && r_ch_en[r_ch]) begin
            if (w_cur != 16'd0)
               r_count[r_ch] <= w_dec;
            else if (!r_oneshot[r_ch])
               r_count[r_ch] <= r_period[r_ch];
            else
               r_ch_en[r_ch] <= 1'b0;
         end

         r_pending <= (r_pending & ~w_w1c) | w_set;

         // CPU writes come last so they override same-cycle hardware updates
         if (w_wr) begin
            case (w_off)
               4'h0: r_gen      <= data_in[0];
               4'h1: r_prescale <= data_in;
               4'h2: r_ch_en    <= data_in[NUM_CH-1:0];
               4'h3: r_oneshot  <= data_in[NUM_CH-1:0];
               4'h5: r_mask     <= data_in[NUM_CH-1:0];
               default: begin
                  if (w_off[3]) begin
                     if (w_off[0]) begin
                        r_period[w_idx][15:8] <= data_in;
                        r_count[w_idx]        <= {data_in, r_period[w_idx][7:0]};
                     end else begin
                        r_period[w_idx][7:0]  <= data_in;
                     end
                  end
               end
            endcase
         end
      end
   end

   always_comb begin
      w_rdata = 8'h00;
      case (w_off)
         4'h0: w_rdata = {r_ovr, 6'b000000, r_gen};
         4'h1: w_rdata = r_prescale;
         4'h2: w_rdata = 8'(r_ch_en);
         4'h3: w_rdata = 8'(r_oneshot);
         4'h4: w_rdata = 8'(r_pending);
         4'h5: w_rdata = 8'(r_mask);
         default: begin
            if (w_off[3])
               w_rdata = w_off[0] ? r_period[w_idx][15:8] : r_period[w_idx][7:0];
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         data_out  <= 8'h00;
         interrupt <= 1'b0;
      end else begin
         data_out  <= w_sel ? w_rdata : 8'h00;
         interrupt <= |(r_pending & r_mask);
      end
   end

endmodule

// File: tb/tb_pb_timer_sched.sv
// Self-checking bench for pb_timer_sched: register table, directed timing
// sequences and randomized channel configurations against an arithmetic expiry model.
module tb_pb_timer_sched;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] port_id;
   logic [7:0] data_in;
   logic [7:0] data_out;
   logic       read_strobe;
   logic       write_strobe;
   logic       interrupt;

   int checks   = 0;
   int failures = 0;
   int edge_n   = 0;

   pb_timer_sched #(.BASE_ADDRESS(8'h00), .NUM_CH(4)) dut (
      .clk          (clk),
      .reset        (reset),
      .port_id      (port_id),
      .data_in      (data_in),
      .data_out     (data_out),
      .read_strobe  (read_strobe),
      .write_strobe (write_strobe),
      .interrupt    (interrupt)
   );

   always #5 clk = ~clk;
   always @(posedge clk) edge_n <= edge_n + 1;

   typedef struct {
      logic       wr;
      logic [7:0] addr;
      logic [7:0] data;
      logic [7:0] exp;
   } vec_t;

   localparam int NV = 27;
   vec_t tbl [NV];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // All bus tasks start and end at a falling edge
   task automatic wr(input logic [7:0] a, input logic [7:0] d);
      port_id = a; data_in = d; write_strobe = 1'b1; read_strobe = 1'b0;
      @(negedge clk);
      write_strobe = 1'b0;
   endtask

   task automatic rd(input logic [7:0] a, output logic [7:0] d);
      port_id = a; read_strobe = 1'b1; write_strobe = 1'b0;
      @(negedge clk);
      read_strobe = 1'b0;
      d = data_out;
   endtask

   task automatic do_reset();
      reset = 1'b1; port_id = 8'h00; data_in = 8'h00;
      write_strobe = 1'b0; read_strobe = 1'b0;
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic wait_irq(input int budget, output int t);
      bit found;
      found = 1'b0;
      t = -1;
      for (int i = 0; i < budget && !found; i++) begin
         if (interrupt === 1'b1) begin
            t = edge_n;
            found = 1'b1;
         end else begin
            @(negedge clk);
         end
      end
   endtask

   int         g, t, t2, gend, P;
   logic [7:0] d;
   logic [3:0] en, os, cur, prev, rise;
   int         per [4];
   int         exp_q [4][$];

   initial begin
      tbl[0]  = '{1'b0, 8'h00, 8'h00, 8'h00};
      tbl[1]  = '{1'b0, 8'h01, 8'h00, 8'h00};
      tbl[2]  = '{1'b0, 8'h02, 8'h00, 8'h00};
      tbl[3]  = '{1'b0, 8'h03, 8'h00, 8'h00};
      tbl[4]  = '{1'b0, 8'h04, 8'h00, 8'h00};
      tbl[5]  = '{1'b0, 8'h05, 8'h00, 8'h00};
      tbl[6]  = '{1'b0, 8'h08, 8'h00, 8'h00};
      tbl[7]  = '{1'b0, 8'h09, 8'h00, 8'h00};
      tbl[8]  = '{1'b0, 8'h0E, 8'h00, 8'h00};
      tbl[9]  = '{1'b0, 8'h0F, 8'h00, 8'h00};
      tbl[10] = '{1'b1, 8'h01, 8'h09, 8'h00};
      tbl[11] = '{1'b1, 8'h05, 8'hFF, 8'h00};
      tbl[12] = '{1'b1, 8'h08, 8'h34, 8'h00};
      tbl[13] = '{1'b1, 8'h09, 8'h12, 8'h00};
      tbl[14] = '{1'b1, 8'h06, 8'hAA, 8'h00};
      tbl[15] = '{1'b1, 8'h03, 8'h5A, 8'h00};
      tbl[16] = '{1'b0, 8'h01, 8'h00, 8'h09};
      tbl[17] = '{1'b0, 8'h05, 8'h00, 8'h0F};
      tbl[18] = '{1'b0, 8'h08, 8'h00, 8'h34};
      tbl[19] = '{1'b0, 8'h09, 8'h00, 8'h12};
      tbl[20] = '{1'b0, 8'h06, 8'h00, 8'h00};
      tbl[21] = '{1'b0, 8'h03, 8'h00, 8'h0A};
      tbl[22] = '{1'b0, 8'h11, 8'h00, 8'h00};
      tbl[23] = '{1'b0, 8'h89, 8'h00, 8'h00};
      tbl[24] = '{1'b1, 8'h0F, 8'hC3, 8'h00};
      tbl[25] = '{1'b0, 8'h0F, 8'h00, 8'hC3};
      tbl[26] = '{1'b0, 8'h0A, 8'h00, 8'h00};

      reset = 1'b1; port_id = 8'h00; data_in = 8'h00;
      read_strobe = 1'b0; write_strobe = 1'b0;
      @(negedge clk); @(negedge clk);
      chk("rst_dout", data_out, 0);
      chk("rst_irq", interrupt, 0);
      reset = 1'b0;

      // Register access table
      for (int i = 0; i < NV; i++) begin
         if (tbl[i].wr) wr(tbl[i].addr, tbl[i].data);
         else begin
            rd(tbl[i].addr, d);
            chk($sformatf("reg_%0d_a%02h", i, tbl[i].addr), d, tbl[i].exp);
         end
      end

      // Periodic channel 0: expiry every 4 ticks of 10 clocks
      do_reset();
      wr(8'h01, 8'd9); wr(8'h08, 8'd3); wr(8'h09, 8'd0); wr(8'h02, 8'h01); wr(8'h05, 8'h01);
      g = edge_n + 1; wr(8'h00, 8'h01);
      wait_irq(100, t);
      chk("per_first", t, g + 42);
      rd(8'h04, d);
      chk("per_pending", d, 8'h01);
      wr(8'h04, 8'h01);
      @(negedge clk);
      chk("per_irq_clr", interrupt, 0);
      wait_irq(100, t2);
      chk("per_second", t2, t + 40);

      // One-shot channel 2 with PERIOD 0
      do_reset();
      wr(8'h01, 8'd9); wr(8'h0C, 8'd0); wr(8'h0D, 8'd0); wr(8'h03, 8'h04);
      wr(8'h02, 8'h04); wr(8'h05, 8'h04);
      g = edge_n + 1; wr(8'h00, 8'h01);
      wait_irq(60, t);
      chk("os_first", t, g + 14);
      rd(8'h02, d); chk("os_chen", d, 8'h00);
      rd(8'h04, d); chk("os_pend", d, 8'h04);
      wr(8'h04, 8'h04);
      repeat (60) @(negedge clk);
      rd(8'h04, d); chk("os_no_more", d, 8'h00);
      chk("os_irq", interrupt, 0);

      // Overrun with PRESCALE 0
      do_reset();
      wr(8'h02, 8'h0F);
      g = edge_n + 1; wr(8'h00, 8'h01);
      repeat (2) @(negedge clk);
      wr(8'h00, 8'h00);
      rd(8'h00, d); chk("ovr_set", d, 8'h80);
      rd(8'h00, d); chk("ovr_clr", d, 8'h00);
      repeat (8) @(negedge clk);
      rd(8'h00, d); chk("ovr_paused", d, 8'h00);

      // W1C colliding with channel-1 expiry on tick 2
      do_reset();
      wr(8'h01, 8'd9); wr(8'h0A, 8'd0); wr(8'h0B, 8'd0); wr(8'h02, 8'h02);
      g = edge_n + 1; wr(8'h00, 8'h01);
      while (edge_n < g + 21) @(negedge clk);
      wr(8'h04, 8'h02);
      rd(8'h04, d); chk("coll_w1c", d, 8'h02);

      // PERIOD1_hi write colliding with channel-1 visit on tick 2
      do_reset();
      wr(8'h01, 8'd9); wr(8'h05, 8'h02); wr(8'h0A, 8'd3); wr(8'h0B, 8'd0); wr(8'h02, 8'h02);
      g = edge_n + 1; wr(8'h00, 8'h01);
      while (edge_n < g + 21) @(negedge clk);
      wr(8'h0B, 8'h00);
      wait_irq(100, t);
      chk("coll_load", t, g + 63);

      // Reset during the channel-2 visit of tick 5
      do_reset();
      wr(8'h01, 8'd9); wr(8'h08, 8'd3); wr(8'h09, 8'd0); wr(8'h02, 8'h01); wr(8'h05, 8'h01);
      g = edge_n + 1; wr(8'h00, 8'h01);
      port_id = 8'h01;
      while (edge_n < g + 52) @(negedge clk);
      chk("mid_pre_irq", interrupt, 1);
      reset = 1'b1;
      #1;
      chk("mid_dout", data_out, 0);
      chk("mid_irq", interrupt, 0);
      @(negedge clk);
      reset = 1'b0;
      rd(8'h01, d); chk("mid_ps", d, 8'h00);
      rd(8'h02, d); chk("mid_chen", d, 8'h00);
      rd(8'h04, d); chk("mid_pend", d, 8'h00);
      wr(8'h01, 8'd9); wr(8'h08, 8'd3); wr(8'h09, 8'd0); wr(8'h02, 8'h01); wr(8'h05, 8'h01);
      g = edge_n + 1; wr(8'h00, 8'h01);
      wait_irq(100, t);
      chk("mid_first", t, g + 42);

      // Randomized channel sets; no overrun for PRESCALE >= 4
      for (int r = 0; r < 3; r++) begin
         do_reset();
         P  = $urandom_range(9, 4);
         en = 4'($urandom_range(15, 1));
         os = 4'($urandom_range(15, 0));
         for (int n = 0; n < 4; n++) begin
            per[n] = $urandom_range(7, 0);
            wr(8'(8 + 2 * n), 8'(per[n]));
            wr(8'(9 + 2 * n), 8'h00);
         end
         wr(8'h01, 8'(P)); wr(8'h03, {4'h0, os}); wr(8'h02, {4'h0, en}); wr(8'h05, 8'h0F);
         g = edge_n + 1; wr(8'h00, 8'h01);
         gend = g + 300;
         // tick k lands at g+k*(P+1); channel n sets PENDING n+1 clocks later,
         // and a held PENDING read shows it one clock after that
         for (int n = 0; n < 4; n++) begin
            exp_q[n].delete();
            if (en[n]) begin
               for (int k = 1; g + k * (P + 1) + n + 2 <= gend; k++) begin
                  if (k % (per[n] + 1) == 0) begin
                     exp_q[n].push_back(g + k * (P + 1) + n + 2);
                     if (os[n]) break;
                  end
               end
            end
         end
         port_id = 8'h04; prev = 4'h0;
         while (edge_n <= gend) begin
            cur  = data_out[3:0];
            rise = cur & ~prev;
            for (int n = 0; n < 4; n++) begin
               if (rise[n]) begin
                  if (exp_q[n].size() == 0)
                     chk($sformatf("rnd%0d_ch%0d_extra", r, n), edge_n, 32'hFFFF_FFFF);
                  else
                     chk($sformatf("rnd%0d_ch%0d_time", r, n), edge_n, exp_q[n].pop_front());
               end
            end
            prev = cur;
            data_in = {4'h0, rise};
            write_strobe = |rise;
            @(negedge clk);
         end
         write_strobe = 1'b0;
         for (int n = 0; n < 4; n++)
            chk($sformatf("rnd%0d_ch%0d_missing", r, n), exp_q[n].size(), 0);
         rd(8'h02, d);
         chk($sformatf("rnd%0d_chen", r), d, {4'h0, en & ~os});
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/pb_timer_sched.md
Name: pb_timer_sched

Overview:
Picoblaze I/O peripheral that schedules four independent 16-bit virtual timer channels onto one shared decrementer. A prescaler generates ticks. On each tick an FSM scans the channels, one per clock, and updates each channel's count. Expiries set pending bits, and the masked pending bits are ORed into one interrupt line. It sits on the same port_id/data_in/data_out strobe bus as the other Picoblaze peripherals.

Parameters:
BASE_ADDRESS, 8'h00, block base; decode is port_id[7:4] == BASE_ADDRESS[7:4]; offset is port_id[3:0]
NUM_CH, 4, number of channels; fixed at 4 and the register map assumes this value

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
port_id  input  8  Picoblaze port address
data_in  input  8  write data
data_out  output  8  registered read data
read_strobe  input  1  read qualifier; used only to clear-on-read of OVR
write_strobe  input  1  write qualifier
interrupt  output  1  registered; equals |(PENDING & IRQ_MASK)

Behaviour:
Register map (offset, access, contents):
- 0x0 CTRL (R/W): bit0 = GEN (global enable); bit7 = OVR (tick overrun, read-only). OVR clears on a read of CTRL when read_strobe is high.
- 0x1 PRESCALE (R/W): 8 bits; one tick every PRESCALE+1 clocks while GEN=1.
- 0x2 CH_EN (R/W, bits[3:0]): channel enables; hardware clears a channel's bit on a one-shot expiry.
- 0x3 CH_ONESHOT (R/W, bits[3:0]).
- 0x4 PENDING (R/W1C, bits[3:0]).
- 0x5 IRQ_MASK (R/W, bits[3:0]).
- 0x8+2n / 0x9+2n (R/W): PERIOD[n] low / high byte. A write to the high byte also loads COUNT[n] = {high, PERIOD_lo}.
- Unmapped offsets read 0; writes to them are ignored.

Reads:
- data_out is registered and valid 1 clock after port_id presents a matched address.
- When the address does not match, data_out = 0.

Prescaler:
- 8-bit counter, cleared while GEN=0.
- When the counter equals PRESCALE it emits a 1-clock tick pulse and reloads to 0.
- A write to PRESCALE resets the counter to 0.

Scheduler FSM:
- IDLE: on a tick, or with tick_q set, go to SCAN with ch=0 and clear tick_q.
- SCAN: visits channel ch in one clock; ch increments; after ch=3 return to IDLE. A full scan is 4 clocks.
- Channel visit with CH_EN[ch]=0: no change.
- Channel visit with CH_EN[ch]=1 and COUNT != 0: COUNT -= 1.
- Channel visit with CH_EN[ch]=1 and COUNT == 0: set PENDING[ch]. Then:
  - periodic channel: COUNT = PERIOD;
  - one-shot channel: CH_EN[ch] cleared and COUNT stays 0.
- Expiry interval is therefore PERIOD+1 ticks. PERIOD=0 expires on every tick.
- Tick arriving during SCAN: stored in tick_q (one deep).
- Tick arriving while tick_q is already set: the tick is dropped and OVR is set.
- Any PRESCALE value below 4 can overrun.
- GEN cleared mid-scan: the current scan completes, and tick_q is cleared.

Simultaneous events:
- Hardware set of PENDING[n] and W1C of the same bit in the same clock: the set wins.
- CPU write to PERIOD_hi[n] in the same clock the FSM visits channel n: the CPU load wins and the decrement or reload is discarded.
- CPU write to CH_EN in the same clock as a hardware one-shot clear: the CPU value wins.

Other rules:
- COUNT never wraps; 0 is the terminal value.
- Arithmetic is a single shared 16-bit decrementer, muxed by ch.
- interrupt is registered, so it updates 1 clock after PENDING or IRQ_MASK changes.

Reset:
- All registers, COUNT, PERIOD, prescaler, tick_q and OVR go to 0.
- FSM goes to IDLE.
- data_out = 0 and interrupt = 0.
- Reset is honoured mid-scan, with no partial update after release.

Test Plan:
1. Reset and register access: after reset, every register readback = 0 and interrupt = 0. Write PRESCALE=8'h09, IRQ_MASK=4'hF and PERIOD0=16'h1234, then read back. Each read value appears on data_out exactly 1 clock after the address, and unmapped offset 0x6 reads 8'h00.
2. Periodic channel: PRESCALE=9, PERIOD0=3, CH_EN=1, MASK=1, GEN=1. PENDING[0] sets every 40 clocks (4 ticks × 10 clocks) and interrupt rises 1 clock later. A W1C of 0x01 drops interrupt, and the next expiry is 40 clocks after the previous one.
3. One-shot channel: PERIOD2=0, CH_ONESHOT=4, CH_EN=4. Exactly one expiry occurs, on the first tick. CH_EN then reads 0, COUNT2 stays 0, and no further PENDING[2] sets occur.
4. Overrun: PRESCALE=0 with all four channels enabled. OVR sets within 3 ticks. A CTRL read returns bit7=1, and the next CTRL read returns bit7=0 while ticks are paused.
5. Collisions: a W1C of PENDING[1] in the same clock as a channel-1 expiry leaves PENDING[1]=1. A PERIOD1_hi write in the same clock as the channel-1 visit loads the written value with no decrement.
6. Reset mid-scan: assert reset during SCAN with ch=2. All outputs go to 0 immediately. After release and reconfiguration, the first expiry timing matches scenario 2.
